// File: rtl/lzx_vote_checker.sv
// Self-test engine for a 3-input majority voter: steps {A,B,C} through 000..111 and checks Y per pattern.
// Latency: busy the edge after start; done exactly 8*HOLD_CYCLES edges after the start edge.
// Backpressure: none; start is taken only in IDLE/DONE and ignored while a run is in progress.
module lzx_vote_checker #(
  parameter int unsigned HOLD_CYCLES  = 20,
  parameter logic [7:0]  EXPECT_TABLE = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vector,
  output logic [2:0] cur_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Y is sampled when the hold counter reaches this value (last cycle of a pattern).
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [2:0] cur_idx_nxt;
  logic [3:0] err_count_nxt;
  logic [7:0] fail_vector_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       pass_nxt;

  logic       pattern_end;
  logic       y_mismatch;

  assign pattern_end = (hold_cnt == HOLD_LAST);
  assign y_mismatch  = (y_i != EXPECT_TABLE[cur_idx]);

  // Stimulus pins are the pattern index register itself, so they are flop outputs.
  assign a_o = cur_idx[2];
  assign b_o = cur_idx[1];
  assign c_o = cur_idx[0];

  // State register; reset drops any run in progress straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic; every target defaults to holding its value.
  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    cur_idx_nxt     = cur_idx;
    err_count_nxt   = err_count;
    fail_vector_nxt = fail_vector;
    busy_nxt        = busy;
    done_nxt        = done;
    pass_nxt        = pass;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt       = ST_DRIVE;
          hold_cnt_nxt    = 8'd0;
          cur_idx_nxt     = 3'd0;
          err_count_nxt   = 4'd0;
          fail_vector_nxt = 8'd0;
          busy_nxt        = 1'b1;
          done_nxt        = 1'b0;
          pass_nxt        = 1'b0;
        end
      end

      ST_DRIVE: begin
        hold_cnt_nxt = hold_cnt + 8'd1;
        if (pattern_end) begin
          hold_cnt_nxt = 8'd0;
          if (y_mismatch) begin
            fail_vector_nxt[cur_idx] = 1'b1;
            err_count_nxt            = err_count + 4'd1;
          end
          if (cur_idx == 3'd7) begin
            // pass uses the updated count so a final-pattern miss is included.
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_count_nxt == 4'd0);
          end else begin
            cur_idx_nxt = cur_idx + 3'd1;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_nxt       = ST_DRIVE;
          hold_cnt_nxt    = 8'd0;
          cur_idx_nxt     = 3'd0;
          err_count_nxt   = 4'd0;
          fail_vector_nxt = 8'd0;
          busy_nxt        = 1'b1;
          done_nxt        = 1'b0;
          pass_nxt        = 1'b0;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean IDLE with reset-valued outputs.
        state_nxt       = ST_IDLE;
        hold_cnt_nxt    = 8'd0;
        cur_idx_nxt     = 3'd0;
        err_count_nxt   = 4'd0;
        fail_vector_nxt = 8'd0;
        busy_nxt        = 1'b0;
        done_nxt        = 1'b0;
        pass_nxt        = 1'b0;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= 8'd0;
      cur_idx     <= 3'd0;
      err_count   <= 4'd0;
      fail_vector <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      hold_cnt    <= hold_cnt_nxt;
      cur_idx     <= cur_idx_nxt;
      err_count   <= err_count_nxt;
      fail_vector <= fail_vector_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
    end
  end

endmodule

// File: doc/lzx_vote_checker.md
Name: lzx_vote_checker

Overview:
- Hardware stimulus/response engine for the 3-input majority voter (lzx_rulingtable): the sequential counterpart to its combinational truth table.
- Drives A/B/C through all 8 input combinations, holds each pattern, samples the voter output Y, and compares it against an expected table.
- Reports per-pattern failures and a pass flag, so the voter can be self-tested on board without a simulator bench.

Parameters:
- HOLD_CYCLES, 20, clock cycles each pattern is held (legal range 2..255); Y is sampled on the last hold cycle.
- EXPECT_TABLE, 8'hE8, expected Y per pattern; bit index = {A,B,C}. Majority gives 1 at 011, 101, 110 and 111.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- a_o  output  1  stimulus A to the voter.
- b_o  output  1  stimulus B to the voter.
- c_o  output  1  stimulus C to the voter.
- y_i  input  1  voter output Y, combinational from a_o/b_o/c_o on the same clock domain; no synchroniser.
- busy  output  1  high while patterns are being driven.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  valid while done=1; 1 when err_count==0.
- err_count  output  4  number of mismatching patterns, 0..8.
- fail_vector  output  8  bit i set when pattern i mismatched.
- cur_idx  output  3  index of the pattern currently driven.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - State goes to IDLE.
  - a_o/b_o/c_o = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vector = 0, cur_idx = 0, hold counter = 0.
- All outputs are registered.
- {a_o,b_o,c_o} always equals cur_idx.
- State IDLE:
  - Outputs hold their reset values.
  - start=1 at a clock edge: clear err_count, fail_vector and cur_idx; clear hold counter; set busy=1; go to DRIVE.
- State DRIVE:
  - The hold counter increments each cycle.
  - When the counter equals HOLD_CYCLES-1, y_i is compared with EXPECT_TABLE[cur_idx] at that edge.
  - On mismatch: set fail_vector[cur_idx] and increment err_count.
  - At that same edge, the hold counter returns to 0.
  - If cur_idx<7, cur_idx increments and the state stays DRIVE.
  - If cur_idx==7, go to DONE. cur_idx stays 7 and a_o/b_o/c_o stay 111.
- Pattern order is 000, 001, 010, 011, 100, 101, 110, 111. Each pattern is held exactly HOLD_CYCLES cycles.
- start is ignored while busy=1; a run cannot be restarted mid-way.
- State DONE:
  - busy=0, done=1.
  - pass = (err_count==0), registered on entry.
  - err_count and fail_vector are frozen.
  - start=1 behaves exactly as in IDLE: clear results, done=0, busy=1, go to DRIVE.
- Latency: start sampled at edge N gives busy=1 after edge N and done=1 after edge N+8*HOLD_CYCLES. With default HOLD_CYCLES this is 160 cycles.
- Simultaneous events:
  - A mismatch on the final pattern is counted before pass is computed. pass reflects all 8 comparisons.
  - rst overrides start.
- err_count cannot overflow: at most 8 increments per run, width 4.
- The FSM uses exactly the 3 states; an illegal state encoding recovers to IDLE.

Test Plan:
- Correct majority voter connected, start pulse → busy for 160 cycles; then done=1, pass=1, err_count=0, fail_vector=8'h00; a_o/b_o/c_o step 000→111 every 20 cycles.
- y_i tied 0 → done after 160 cycles; fail_vector=8'hE8, err_count=4, pass=0.
- y_i tied 1 → fail_vector=8'h17, err_count=4, pass=0.
- Faulty voter Y=A&B&C → fail_vector=8'h68 (patterns 011, 101, 110), err_count=3, pass=0.
- Control-path checks:
  - start re-pulsed at cycle 50 of a run → ignored; done still at cycle 160.
  - rst asserted at cycle 70 → all outputs 0 immediately.
  - A new start then produces a full correct run.
- Parameter override HOLD_CYCLES=2 with correct voter → done after 16 cycles, pass=1.
- start in DONE → results cleared, and a second run gives identical results.
